// File: rtl/pc_sequencer.sv
// Instruction-sequencing controller for a shared program-counter up-counter.
// Boots to a reset vector, runs a fetch/execute/advance loop with a small
// return stack for call/return, and parks in HALT when asked. Every output
// is a register fed from the next-state decode, so a pulse is visible during
// the state it belongs to.
module pc_sequencer #(
    parameter int unsigned         WIDTH        = 8,
    parameter int unsigned         STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_target,
    output logic             fetch_req,
    input  logic             fetch_ack,
    output logic             exec_start,
    input  logic             exec_done,
    input  logic [1:0]       exec_op,
    input  logic [WIDTH-1:0] exec_target,
    input  logic             halt_req,
    output logic             halted,
    output logic             stack_err
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = PTR_W + 1;

    localparam logic [1:0] OpNext = 2'b00;
    localparam logic [1:0] OpJump = 2'b01;
    localparam logic [1:0] OpCall = 2'b10;
    localparam logic [1:0] OpRet  = 2'b11;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StExec,
        StAdvance,
        StHalt
    } state_t;

    state_t state_q, state_d;

    // Output registers
    logic             pc_inc_q, pc_inc_d;
    logic             pc_load_q, pc_load_d;
    logic [WIDTH-1:0] pc_target_q, pc_target_d;
    logic             fetch_req_q, fetch_req_d;
    logic             exec_start_q, exec_start_d;
    logic             halted_q, halted_d;

    // Return stack
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic             stack_err_q;

    logic             stack_full, stack_empty;
    logic [SP_W-1:0]  sp_dec;
    logic [PTR_W-1:0] top_idx, wr_idx;
    logic [WIDTH-1:0] ret_addr;
    logic             push, pop, set_err;

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign sp_dec      = sp_q - SP_W'(1);
    assign top_idx     = sp_dec[PTR_W-1:0];
    assign wr_idx      = sp_q[PTR_W-1:0];
    assign ret_addr    = pc + WIDTH'(1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; BOOT spends its first cycle arming the reset-vector
    // load and leaves once that load pulse is on the output.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot:    if (pc_load_q) state_d = StFetch;
            StFetch:   if (fetch_ack) state_d = StExec;
            StExec:    if (exec_done) state_d = StAdvance;
            StAdvance: state_d = halt_req ? StHalt : StFetch;
            StHalt:    state_d = StHalt;
            default:   state_d = StBoot;
        endcase
    end

    // Output and stack-action decode; the instruction action is resolved on
    // exec_done so it appears registered during ADVANCE.
    always_comb begin
        pc_inc_d     = 1'b0;
        pc_load_d    = 1'b0;
        pc_target_d  = '0;
        push         = 1'b0;
        pop          = 1'b0;
        set_err      = 1'b0;
        fetch_req_d  = (state_d == StFetch);
        exec_start_d = (state_q == StFetch) && fetch_ack;
        halted_d     = (state_d == StHalt);
        if (state_q == StBoot && !pc_load_q) begin
            pc_load_d   = 1'b1;
            pc_target_d = RESET_VECTOR;
        end else if (state_q == StExec && exec_done) begin
            case (exec_op)
                OpNext: pc_inc_d = 1'b1;
                OpJump: begin
                    pc_load_d   = 1'b1;
                    pc_target_d = exec_target;
                end
                OpCall: begin
                    pc_load_d   = 1'b1;
                    pc_target_d = exec_target;
                    // A full stack drops the push but still takes the jump.
                    if (stack_full) set_err = 1'b1;
                    else            push    = 1'b1;
                end
                OpRet: begin
                    if (stack_empty) begin
                        set_err  = 1'b1;
                        pc_inc_d = 1'b1;
                    end else begin
                        pop         = 1'b1;
                        pc_load_d   = 1'b1;
                        pc_target_d = stack_q[top_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_inc_q     <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_target_q  <= '0;
            fetch_req_q  <= 1'b0;
            exec_start_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            pc_inc_q     <= pc_inc_d;
            pc_load_q    <= pc_load_d;
            pc_target_q  <= pc_target_d;
            fetch_req_q  <= fetch_req_d;
            exec_start_q <= exec_start_d;
            halted_q     <= halted_d;
        end
    end

    // Return stack pointer, entries and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            if (push) begin
                stack_q[wr_idx] <= ret_addr;
                sp_q            <= sp_q + SP_W'(1);
            end else if (pop) begin
                sp_q <= sp_dec;
            end
            if (set_err) begin
                stack_err_q <= 1'b1;
            end
        end
    end

    assign pc_inc     = pc_inc_q;
    assign pc_load    = pc_load_q;
    assign pc_target  = pc_target_q;
    assign fetch_req  = fetch_req_q;
    assign exec_start = exec_start_q;
    assign halted     = halted_q;
    assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table, hand-written
// halt/reset sequences, and a randomized run against an instruction-level model.
module tb_pc_sequencer;

    localparam int unsigned    W     = 8;
    localparam int unsigned    DEPTH = 4;
    localparam logic [W-1:0]   RV    = 8'h10;

    logic         clk, reset;
    logic [W-1:0] pc;
    logic         pc_inc, pc_load;
    logic [W-1:0] pc_target;
    logic         fetch_req, fetch_ack, exec_start, exec_done;
    logic [1:0]   exec_op;
    logic [W-1:0] exec_target;
    logic         halt_req, halted, stack_err;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(
        .WIDTH       (W),
        .STACK_DEPTH (DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .fetch_req  (fetch_req),
        .fetch_ack  (fetch_ack),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .exec_op    (exec_op),
        .exec_target(exec_target),
        .halt_req   (halt_req),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared program counter the sequencer drives
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pc <= '0;
        else if (pc_load) pc <= pc_target;
        else if (pc_inc)  pc <= pc + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle invariants
    always @(negedge clk) begin
        if (!reset) begin
            check("inc_load_excl", {31'd0, pc_inc & pc_load}, 32'd0);
            if (!pc_load) check("target_idle", {24'd0, pc_target}, 32'd0);
            if (halted) check("halt_quiet", {28'd0, fetch_req, exec_start, pc_inc, pc_load}, 32'd0);
        end
    end

    task automatic release_boot();
        reset = 1'b0;
        @(negedge clk);
        check("boot_load", {23'd0, pc_load, pc_target}, {23'd0, 1'b1, RV});
        @(negedge clk);
        check("boot_fetch", {22'd0, pc_load, fetch_req, pc}, {22'd0, 1'b0, 1'b1, RV});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fetch_ack = 1'b0; exec_done = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        check("reset_outs", {18'd0, pc_inc, pc_load, pc_target, fetch_req, exec_start, halted,
                             stack_err}, 32'd0);
        release_boot();
    endtask

    // One instruction: fetch handshake, execute, sample ADVANCE, then the next state.
    task automatic run_instr(input logic [1:0] op, input logic [W-1:0] tgt, input int ack_dly,
                             input int done_dly, input logic halt, input logic noise,
                             output logic g_inc, output logic g_load, output logic [W-1:0] g_tgt,
                             output logic g_err, output time adv_t);
        int   waited = 0;
        logic ok = 1'b1;
        g_inc = 0; g_load = 0; g_tgt = 0; g_err = 0; adv_t = 0;
        while (!fetch_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("fetch_req_seen", {31'd0, fetch_req}, 32'd1);
        if (!fetch_req) return;
        for (int k = 0; k < ack_dly; k++) begin
            exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            ok &= fetch_req & ~exec_start & ~pc_inc & ~pc_load;
        end
        check("fetch_hold", {31'd0, ok}, 32'd1);
        exec_done = 1'b0;
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        check("exec_start", {30'd0, exec_start, fetch_req}, 32'd2);
        ok = 1'b1;
        for (int k = 0; k < done_dly; k++) begin
            fetch_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            ok &= ~exec_start & ~pc_inc & ~pc_load & ~fetch_req;
        end
        check("exec_wait_quiet", {31'd0, ok}, 32'd1);
        fetch_ack   = 1'b0;
        exec_op     = op;
        exec_target = tgt;
        exec_done   = 1'b1;
        halt_req    = halt;
        @(negedge clk);
        exec_done = 1'b0;
        exec_op   = 2'($urandom_range(0, 3));
        g_inc = pc_inc; g_load = pc_load; g_tgt = pc_target; g_err = stack_err; adv_t = $time;
        check("adv_no_fetch", {31'd0, fetch_req}, 32'd0);
        @(negedge clk);
        halt_req = 1'b0;
        check("single_pulse", {30'd0, pc_inc, pc_load}, 32'd0);
        check("halted_state", {30'd0, halted, fetch_req}, {30'd0, halt, ~halt});
    endtask

    typedef struct {
        logic         rst;
        logic [1:0]   op;
        logic [W-1:0] tgt;
        int           ack_dly;
        int           done_dly;
        logic         e_inc;
        logic         e_load;
        logic [W-1:0] e_tgt;
        logic         e_err;
        logic [W-1:0] e_pc;
    } vec_t;

    initial begin
        vec_t         tbl[$];
        logic         g_inc, g_load, g_err, ok;
        logic [W-1:0] g_tgt;
        time          adv_t, prev_t;
        logic [W-1:0] mpc, ra, e_tgt;
        logic [W-1:0] mstk[$];
        logic         merr, e_inc, e_load;
        logic [1:0]   op;
        logic [W-1:0] tgt;

        reset = 1'b1; fetch_ack = 0; exec_done = 0; exec_op = 0; exec_target = 0; halt_req = 0;
        prev_t = 0;

        //               rst op     tgt   ack dn inc ld  etgt   err epc
        tbl.push_back('{1'b1, 2'd0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 8'h11});
        tbl.push_back('{1'b0, 2'd0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 8'h12});
        tbl.push_back('{1'b0, 2'd0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 8'h13});
        tbl.push_back('{1'b0, 2'd1, 8'h22, 5, 4, 0, 1, 8'h22, 0, 8'h22});
        tbl.push_back('{1'b0, 2'd2, 8'h80, 0, 1, 0, 1, 8'h80, 0, 8'h80});
        tbl.push_back('{1'b0, 2'd3, 8'h99, 1, 0, 0, 1, 8'h23, 0, 8'h23});
        tbl.push_back('{1'b0, 2'd1, 8'hFF, 0, 0, 0, 1, 8'hFF, 0, 8'hFF});
        tbl.push_back('{1'b0, 2'd2, 8'h05, 0, 0, 0, 1, 8'h05, 0, 8'h05});
        tbl.push_back('{1'b0, 2'd3, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h00});
        tbl.push_back('{1'b0, 2'd2, 8'h30, 2, 1, 0, 1, 8'h30, 0, 8'h30});
        tbl.push_back('{1'b0, 2'd2, 8'h40, 0, 0, 0, 1, 8'h40, 0, 8'h40});
        tbl.push_back('{1'b0, 2'd2, 8'h50, 0, 0, 0, 1, 8'h50, 0, 8'h50});
        tbl.push_back('{1'b0, 2'd2, 8'h60, 0, 0, 0, 1, 8'h60, 0, 8'h60});
        tbl.push_back('{1'b0, 2'd2, 8'h70, 0, 0, 0, 1, 8'h70, 1, 8'h70});
        tbl.push_back('{1'b0, 2'd3, 8'h00, 0, 0, 0, 1, 8'h51, 1, 8'h51});
        tbl.push_back('{1'b0, 2'd3, 8'h00, 0, 0, 0, 1, 8'h41, 1, 8'h41});
        tbl.push_back('{1'b0, 2'd3, 8'h00, 0, 0, 0, 1, 8'h31, 1, 8'h31});
        tbl.push_back('{1'b0, 2'd3, 8'h00, 0, 0, 0, 1, 8'h01, 1, 8'h01});
        tbl.push_back('{1'b0, 2'd3, 8'h00, 0, 0, 1, 0, 8'h00, 1, 8'h02});
        tbl.push_back('{1'b1, 2'd3, 8'hAA, 0, 0, 1, 0, 8'h00, 1, 8'h11});
        tbl.push_back('{1'b0, 2'd1, 8'h33, 0, 0, 0, 1, 8'h33, 1, 8'h33});

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            run_instr(tbl[i].op, tbl[i].tgt, tbl[i].ack_dly, tbl[i].done_dly, 1'b0, 1'b0,
                      g_inc, g_load, g_tgt, g_err, adv_t);
            check($sformatf("vec%0d_pulse", i), {22'd0, g_inc, g_load, g_tgt},
                  {22'd0, tbl[i].e_inc, tbl[i].e_load, tbl[i].e_tgt});
            check($sformatf("vec%0d_err", i), {31'd0, g_err}, {31'd0, tbl[i].e_err});
            check($sformatf("vec%0d_pc", i), {24'd0, pc}, {24'd0, tbl[i].e_pc});
            if (i == 1 || i == 2) check("inc_spacing", 32'(adv_t - prev_t), 32'd30);
            prev_t = adv_t;
        end

        // Halt requested during a jump: the jump completes, then nothing more is fetched.
        do_reset();
        run_instr(2'd1, 8'h40, 1, 2, 1'b1, 1'b0, g_inc, g_load, g_tgt, g_err, adv_t);
        check("halt_jump", {22'd0, g_inc, g_load, g_tgt}, {22'd0, 1'b0, 1'b1, 8'h40});
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fetch_ack = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok &= halted & ~fetch_req & ~exec_start & ~pc_inc & ~pc_load;
        end
        fetch_ack = 1'b0; exec_done = 1'b0;
        check("halt_hold", {31'd0, ok}, 32'd1);
        check("halt_pc", {24'd0, pc}, 32'h40);

        // Reset asserted mid-EXEC clears outputs without waiting for a clock edge.
        do_reset();
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        check("pre_reset_exec", {31'd0, exec_start}, 32'd1);
        #2 reset = 1'b1;
        #1 check("async_reset_outs", {18'd0, pc_inc, pc_load, pc_target, fetch_req, exec_start,
                                      halted, stack_err}, 32'd0);
        @(negedge clk);
        release_boot();

        // Randomized instructions against an instruction-level model.
        do_reset();
        mpc = RV; mstk.delete(); merr = 1'b0;
        for (int n = 0; n < 160; n++) begin
            if (n % 40 == 39) begin
                do_reset();
                mpc = RV; mstk.delete(); merr = 1'b0;
            end
            op  = 2'($urandom_range(0, 3));
            tgt = 8'($urandom);
            e_inc = 1'b0; e_load = 1'b0; e_tgt = '0;
            ra = mpc + 8'd1;
            case (op)
                2'd0: e_inc = 1'b1;
                2'd1: begin e_load = 1'b1; e_tgt = tgt; end
                2'd2: begin
                    e_load = 1'b1; e_tgt = tgt;
                    if (mstk.size() < DEPTH) mstk.push_back(ra);
                    else merr = 1'b1;
                end
                default: begin
                    if (mstk.size() > 0) begin e_load = 1'b1; e_tgt = mstk.pop_back(); end
                    else begin merr = 1'b1; e_inc = 1'b1; end
                end
            endcase
            mpc = e_load ? e_tgt : ra;
            run_instr(op, tgt, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1,
                      g_inc, g_load, g_tgt, g_err, adv_t);
            check($sformatf("rand%0d_op%0d", n, op), {13'd0, g_inc, g_load, g_tgt, g_err, pc},
                  {13'd0, e_inc, e_load, e_tgt, merr, mpc});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d failed", n_fail, n_tests);
        $fatal(1);
    end

endmodule
